pick_ctrl: RTL and testbench

Motion controller for the pick sprite. It turns keyboard keycodes into the 3-bit `dir` command that the pick mover consumes, and updates that command only on frame boundaries. A held key accelerates from slow to fast motion after a set number of frames. The block also raises a strum request to the note/scoring logic using a req/ack handshake. It sits between the USB keycode registers and the pick mover, in the `Clk` domain.

---
 rtl/pick_pkg.sv | 20 ++
 rtl/frame_tick_sync.sv | 14 +
 rtl/pick_ctrl.sv | 91 +++++++++
 tb/tb_pick_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pick_pkg.sv
// pick_pkg: shared types and keycodes for the pick motion controller
package pick_pkg;
  typedef enum logic [2:0] {
    DIR_HOLD = 3'b000,
    DIR_UP1  = 3'b001,
    DIR_DN1  = 3'b010,
    DIR_DN2  = 3'b011,
    DIR_UP2  = 3'b100
  } dir_t;
  typedef enum logic [2:0] {IDLE, UP_SLOW, UP_FAST, DN_SLOW, DN_FAST} state_t;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  function automatic dir_t state_dir(input state_t s);
    return s == UP_SLOW ? DIR_UP1 :
           s == UP_FAST ? DIR_UP2 :
           s == DN_SLOW ? DIR_DN1 :
           s == DN_FAST ? DIR_DN2 : DIR_HOLD;
  endfunction
endpackage

// File: rtl/frame_tick_sync.sv
// frame_tick_sync: 2-flop synchronizer plus rising-edge detector giving a one-clock frame pulse
module frame_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tick
);
  logic [2:0] sr;
  // sr[1:0] resynchronize the frame clock, sr[2] remembers the previous level for edge detection
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr <= '0;
    else sr <= {sr[1:0], async_in};
  assign tick = sr[1] & ~sr[2];
endmodule

// File: rtl/pick_ctrl.sv
// pick_ctrl: keycodes to frame-aligned pick motion command plus strum req/ack; PICK_CTRL_CLAMP_EN stops motion at the Y limits
module pick_ctrl
  import pick_pkg::*;
#(
  parameter int HOLD_FRAMES = 8,
  parameter int Y_MIN       = 32,
  parameter int Y_MAX       = 479
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic [9:0] pickY,
  input  logic       strum_ack,
  output logic [2:0] dir,
  output logic       strum_req,
  output logic       fast
);
  localparam logic [3:0] HOLD = 4'(HOLD_FRAMES);
  state_t state, state_n;
  dir_t dir_q;
  logic [3:0] cnt, cnt_n, cnt_inc;
  logic tick, w, s, space, sp_d, sp_dd, stop;
  frame_tick_sync u_sync (.clk(Clk), .rst_n(Reset_n), .async_in(frame_clk), .tick(tick));
  assign w = keycode0 == KEY_W || keycode1 == KEY_W;
  assign s = keycode0 == KEY_S || keycode1 == KEY_S;
  assign space = keycode0 == KEY_SPACE || keycode1 == KEY_SPACE;
  assign cnt_inc = cnt == 4'hF ? cnt : cnt + 4'd1;
  // next state and hold counter; only a frame tick may move the FSM
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (tick) begin
      if (w == s) begin
        state_n = IDLE;
        cnt_n = '0;
      end else if (w) begin
        if (state == UP_SLOW) begin
          cnt_n = cnt_inc;
          state_n = cnt_inc == HOLD ? UP_FAST : UP_SLOW;
        end else if (state != UP_FAST) begin
          state_n = UP_SLOW;
          cnt_n = '0;
        end
      end else begin
        if (state == DN_SLOW) begin
          cnt_n = cnt_inc;
          state_n = cnt_inc == HOLD ? DN_FAST : DN_SLOW;
        end else if (state != DN_FAST) begin
          state_n = DN_SLOW;
          cnt_n = '0;
        end
      end
    end
  end
`ifdef PICK_CTRL_CLAMP_EN
  localparam logic [9:0] Y_LO = 10'(Y_MIN + 2);
  localparam logic [9:0] Y_HI = 10'(Y_MAX - 2);
  assign stop = ((state_n == UP_SLOW || state_n == UP_FAST) && pickY <= Y_LO) ||
                ((state_n == DN_SLOW || state_n == DN_FAST) && pickY >= Y_HI);
`else
  logic unused_clamp;
  assign stop = 1'b0;
  assign unused_clamp = ^{pickY, Y_MIN[0], Y_MAX[0]};
`endif
  // FSM state, counter and the frame-stable dir command
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= IDLE;
      cnt <= '0;
      dir_q <= DIR_HOLD;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (tick) dir_q <= stop ? DIR_HOLD : state_dir(state_n);
    end
  // strum: Space edge register then request flop; ack beats a simultaneous edge
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      sp_d <= 1'b0;
      sp_dd <= 1'b0;
      strum_req <= 1'b0;
    end else begin
      sp_d <= space;
      sp_dd <= sp_d;
      strum_req <= strum_ack ? 1'b0 : strum_req | (sp_d & ~sp_dd);
    end
  assign dir = dir_q;
  assign fast = state == UP_FAST || state == DN_FAST;
endmodule

// File: tb/tb_pick_ctrl.sv
// tb_pick_ctrl: randomized scoreboard bench for pick_ctrl with a frame-level reference model
module tb_pick_ctrl;
  import pick_pkg::*;
  localparam int HOLD = 8;
  localparam int YMIN = 32;
  localparam int YMAX = 479;
  logic Clk = 0, Reset_n = 0, frame_clk = 0, strum_ack = 0;
  logic [7:0] keycode0 = 0, keycode1 = 0;
  logic [9:0] pickY = 10'd200;
  logic [2:0] dir;
  logic strum_req, fast;
  int checks = 0, errors = 0;
  typedef struct {
    logic [2:0] d;
    logic f;
    string tag;
  } fexp_t;
  fexp_t fq[$];
  logic sq[$];
  int run = 0, len = 0;
  logic [2:0] cur_dir = 0;
  logic cur_fast = 0;
  logic ack_en = 0;
  logic p1 = 0, p2 = 0, mreq = 0;

  pick_ctrl #(.HOLD_FRAMES(HOLD), .Y_MIN(YMIN), .Y_MAX(YMAX)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk),
    .keycode0(keycode0), .keycode1(keycode1), .pickY(pickY),
    .strum_ack(strum_ack), .dir(dir), .strum_req(strum_req), .fast(fast)
  );

  always #10 Clk = ~Clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic has(input logic [7:0] a, input logic [7:0] b, input logic [7:0] k);
    return a == k || b == k;
  endfunction

  // strum reference: a Space press seen last cycle but not the one before is a new press
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      p1 = 0;
      p2 = 0;
      mreq = 0;
      sq.delete();
    end else begin
      if (strum_ack) mreq = 0;
      else if (p1 && !p2) mreq = 1;
      p2 = p1;
      p1 = has(keycode0, keycode1, KEY_SPACE);
      sq.push_back(mreq);
    end
  end

  // monitor: pops expectations and compares against DUT outputs
  always @(negedge Clk) begin
    logic e;
    fexp_t f;
    if (Reset_n) begin
      if (sq.size() > 0) begin
        e = sq.pop_front();
        chk("strum_req", {7'd0, strum_req}, {7'd0, e});
      end
      if (fq.size() > 0) begin
        f = fq.pop_front();
        chk({f.tag, " dir"}, {5'd0, dir}, {5'd0, f.d});
        chk({f.tag, " fast"}, {7'd0, fast}, {7'd0, f.f});
      end
    end
  end

  // random strum acknowledgements during the random phase
  initial forever begin
    @(posedge Clk);
    #1;
    if (ack_en) strum_ack = ($urandom_range(0, 3) == 0);
  end

  // one frame: apply keys, pulse frame_clk, expect old dir until 3 clocks after the rising edge
  task automatic frame(input logic [7:0] k0, input logic [7:0] k1, input logic [9:0] py, input string tag);
    logic w, s;
    int d;
    logic [2:0] ed;
    logic ef;
    keycode0 = k0;
    keycode1 = k1;
    pickY = py;
    w = has(k0, k1, KEY_W);
    s = has(k0, k1, KEY_S);
    d = (w == s) ? 0 : (w ? 1 : 2);
    if (d == 0) begin
      run = 0;
      len = 0;
    end else if (d == run) len++;
    else begin
      run = d;
      len = 1;
    end
    ef = run != 0 && len > HOLD;
    ed = run == 0 ? 3'd0 : run == 1 ? (ef ? 3'd4 : 3'd1) : (ef ? 3'd3 : 3'd2);
`ifdef PICK_CTRL_CLAMP_EN
    if ((run == 1 && int'(py) <= YMIN + 2) || (run == 2 && int'(py) >= YMAX - 2)) ed = 3'd0;
`endif
    repeat (2) @(posedge Clk);
    #1 frame_clk = 1;
    repeat (2) @(posedge Clk);
    #1 fq.push_back('{cur_dir, cur_fast, {tag, " pre"}});
    @(posedge Clk);
    #1 fq.push_back('{ed, ef, tag});
    cur_dir = ed;
    cur_fast = ef;
    repeat (4) @(posedge Clk);
    #1 frame_clk = 0;
    fq.push_back('{ed, ef, {tag, " hold"}});
    repeat (4) @(posedge Clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] keys[5];
    keys[0] = 8'h00; keys[1] = KEY_W; keys[2] = KEY_S; keys[3] = KEY_SPACE; keys[4] = 8'h04;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset dir", {5'd0, dir}, 8'd0);
    chk("reset fast", {7'd0, fast}, 8'd0);
    chk("reset strum_req", {7'd0, strum_req}, 8'd0);
    Reset_n = 1;
    @(posedge Clk);
    #1;
    repeat (5) frame(8'h00, 8'h00, 10'd200, "idle");
    for (int i = 0; i < 12; i++) frame(KEY_W, 8'h00, 10'd200, "w_hold");
    for (int i = 0; i < 10; i++) frame(8'h00, KEY_S, 10'd200, "s_hold");
    frame(KEY_W, 8'h00, 10'd200, "s_to_w");
    frame(KEY_W, KEY_S, 10'd200, "w_and_s");
    frame(KEY_W, 8'h00, 10'd34, "w_at_top");
    frame(8'h00, KEY_S, 10'd477, "s_at_bottom");
    frame(8'h00, 8'h00, 10'd200, "idle2");
    // directed strum handshake
    keycode1 = KEY_SPACE;
    @(posedge Clk);
    #1 chk("strum after 1 cycle", {7'd0, strum_req}, 8'd0);
    @(posedge Clk);
    #1 chk("strum after 2 cycles", {7'd0, strum_req}, 8'd1);
    keycode1 = 8'h00;
    repeat (2) @(posedge Clk);
    #1 keycode1 = KEY_SPACE;
    repeat (3) @(posedge Clk);
    #1 chk("strum repress pending", {7'd0, strum_req}, 8'd1);
    strum_ack = 1;
    @(posedge Clk);
    #1 strum_ack = 0;
    chk("strum ack clears", {7'd0, strum_req}, 8'd0);
    repeat (3) @(posedge Clk);
    #1 chk("strum no queued press", {7'd0, strum_req}, 8'd0);
    keycode1 = 8'h00;
    repeat (2) @(posedge Clk);
    #1 keycode1 = KEY_SPACE;
    repeat (3) @(posedge Clk);
    #1 chk("strum second press", {7'd0, strum_req}, 8'd1);
    keycode1 = 8'h00;
    repeat (2) @(posedge Clk);
    #1 keycode1 = KEY_SPACE;
    @(posedge Clk);
    #1 strum_ack = 1;
    @(posedge Clk);
    #1 strum_ack = 0;
    chk("strum ack vs edge", {7'd0, strum_req}, 8'd0);
    repeat (3) @(posedge Clk);
    #1 chk("strum edge dropped", {7'd0, strum_req}, 8'd0);
    keycode1 = 8'h00;
    // randomized frames with random acks
    ack_en = 1;
    for (int i = 0; i < 150; i++) begin
      logic [9:0] py;
      int r;
      r = $urandom_range(0, 3);
      py = r == 0 ? 10'(YMIN + $urandom_range(0, 4)) : r == 1 ? 10'(YMAX - $urandom_range(0, 4)) : 10'($urandom_range(0, 1023));
      if ($urandom_range(0, 2) == 0) frame(keys[$urandom_range(0, 4)], keys[$urandom_range(0, 4)], py, "rand");
      else frame($urandom_range(0, 1) ? KEY_W : KEY_S, $urandom_range(0, 1) ? 8'h00 : KEY_SPACE, py, "rand_run");
    end
    ack_en = 0;
    strum_ack = 0;
    frame(8'h00, 8'h00, 10'd200, "release");
    for (int i = 0; i < 10; i++) frame(KEY_S, KEY_SPACE, 10'd200, "s_space");
    // asynchronous reset mid-frame with a pending strum and DN_FAST
    repeat (3) @(posedge Clk);
    #1 chk("pre-reset strum_req", {7'd0, strum_req}, 8'd1);
    chk("pre-reset fast", {7'd0, fast}, 8'd1);
    chk("pre-reset dir", {5'd0, dir}, 8'd3);
    frame_clk = 1;
    #6 Reset_n = 0;
    strum_ack = 1;
    keycode0 = 8'h00;
    keycode1 = 8'h00;
    frame_clk = 0;
    fq.delete();
    run = 0;
    len = 0;
    cur_dir = 0;
    cur_fast = 0;
    #1 chk("async reset dir", {5'd0, dir}, 8'd0);
    chk("async reset fast", {7'd0, fast}, 8'd0);
    chk("async reset strum_req", {7'd0, strum_req}, 8'd0);
    @(posedge Clk);
    #1 Reset_n = 1;
    repeat (3) @(posedge Clk);
    #1 chk("post-reset held ack", {7'd0, strum_req}, 8'd0);
    strum_ack = 0;
    frame(8'h00, 8'h00, 10'd200, "post_reset");
    repeat (3) @(posedge Clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
